// File: rtl/mult_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : mult_pkg                                                  |
// | Purpose  : Shared FSM state type and counter sizing helper for the   |
// |            shift-add multiplier.                                     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to hold a count from 0 up to and including w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_add_multiplier.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : shift_add_multiplier                                      |
// | Purpose  : Sequential radix-2 shift-add multiplier, one multiplier   |
// |            bit per cycle, optional runtime two's-complement mode.    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH     = 24,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic [2*WIDTH-1:0]   p,
    output logic                 out_en,
    output logic                 busy
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t               state_q,  state_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [2*WIDTH-1:0]   acc_q,    acc_d;
    logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic                 neg_q,    neg_d;
    logic [2*WIDTH-1:0]   p_q,      p_d;
    logic                 out_en_q, out_en_d;

    // Operands are reduced to magnitudes at accept; the sign is re-applied
    // to the finished accumulator. -(-2^(WIDTH-1)) still fits as unsigned.
    logic                 sign_mode;
    logic [WIDTH-1:0]     x_mag;
    logic [WIDTH-1:0]     y_mag;

    assign sign_mode = is_signed & SIGNED_EN;
    assign x_mag     = (sign_mode && x[WIDTH-1]) ? -x : x;
    assign y_mag     = (sign_mode && y[WIDTH-1]) ? -y : y;

    // Next-state and datapath update: accept in IDLE, shift-add in RUN,
    // publish the signed-corrected product when the counter is exhausted.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        p_d      = p_q;
        out_en_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, x_mag};
                    mplier_d = y_mag;
                    neg_d    = sign_mode & (x[WIDTH-1] ^ y[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = CNT_W'(WIDTH);
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (cnt_q != '0) begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - 1'b1;
                end else begin
                    p_d      = neg_q ? -acc_q : acc_q;
                    out_en_d = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            p_q      <= '0;
            out_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            p_q      <= p_d;
            out_en_q <= out_en_d;
        end
    end

    assign p      = p_q;
    assign out_en = out_en_q;
    assign busy   = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_shift_add_multiplier                                   |
// | Purpose  : Directed self-checking bench for shift_add_multiplier,    |
// |            three instances (24-bit, 8-bit, 8-bit unsigned-only).     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  start_v;
    logic [2:0]  sgn_v;
    logic [2:0]  oe_v;
    logic [2:0]  bz_v;
    logic [23:0] x0, y0;
    logic [7:0]  x1, y1, x2, y2;
    logic [47:0] p0;
    logic [15:0] p1, p2;

    int n_checks = 0;
    int n_fail   = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    shift_add_multiplier #(.WIDTH(24), .SIGNED_EN(1'b1)) u_dut0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .is_signed(sgn_v[0]),
        .x(x0), .y(y0), .p(p0), .out_en(oe_v[0]), .busy(bz_v[0]));

    shift_add_multiplier #(.WIDTH(8), .SIGNED_EN(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .is_signed(sgn_v[1]),
        .x(x1), .y(y1), .p(p1), .out_en(oe_v[1]), .busy(bz_v[1]));

    shift_add_multiplier #(.WIDTH(8), .SIGNED_EN(1'b0)) u_dut2 (
        .clk(clk), .reset(reset), .start(start_v[2]), .is_signed(sgn_v[2]),
        .x(x2), .y(y2), .p(p2), .out_en(oe_v[2]), .busy(bz_v[2]));

    function automatic int width_of(input int d);
        return (d == 0) ? 24 : 8;
    endfunction

    function automatic logic [127:0] get_p(input int d);
        case (d)
            0:       return 128'(p0);
            1:       return 128'(p1);
            default: return 128'(p2);
        endcase
    endfunction

    task automatic drive(input int d, input logic s, input logic sg,
                         input logic [63:0] a, input logic [63:0] b);
        start_v[d] = s;
        sgn_v[d]   = sg;
        case (d)
            0:       begin x0 = a[23:0]; y0 = b[23:0]; end
            1:       begin x1 = a[7:0];  y1 = b[7:0];  end
            default: begin x2 = a[7:0];  y2 = b[7:0];  end
        endcase
    endtask

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Caller is at a falling edge. Accept at the next rising edge, scramble
    // the operands right after, then measure latency and the result.
    task automatic launch(input string tag, input int d, input logic sg,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [127:0] exp);
        int k;
        drive(d, 1'b1, sg, a, b);
        @(posedge clk); #1;
        drive(d, 1'b0, ~sg, ~a, ~b);
        check({tag, "_busy_after_accept"}, 128'(bz_v[d]), 128'(1));
        k = 0;
        while (oe_v[d] !== 1'b1 && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_latency"}, 128'(k), 128'(width_of(d) + 1));
        check({tag, "_p"}, get_p(d), exp);
        check({tag, "_busy_at_out_en"}, 128'(bz_v[d]), 128'(1));
        @(posedge clk); #1;
        check({tag, "_out_en_pulse"}, 128'(oe_v[d]), 128'(0));
        check({tag, "_busy_after"}, 128'(bz_v[d]), 128'(0));
        check({tag, "_p_held"}, get_p(d), exp);
    endtask

    task automatic run_op(input string tag, input int d, input logic sg,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [127:0] exp);
        @(negedge clk);
        launch(tag, d, sg, a, b, exp);
    endtask

    // Directed sequence.
    initial begin
        int k;
        int m;
        logic seen;
        reset   = 1'b0;
        start_v = 3'b111;
        sgn_v   = 3'b000;
        x0 = 24'd1; y0 = 24'd1; x1 = 8'd1; y1 = 8'd1; x2 = 8'd1; y2 = 8'd1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_p%0d", d), get_p(d), 128'(0));
            check($sformatf("reset_out_en%0d", d), 128'(oe_v[d]), 128'(0));
            check($sformatf("reset_busy%0d", d), 128'(bz_v[d]), 128'(0));
        end
        start_v = 3'b000;

        // First start accepted on the first edge with reset released.
        @(negedge clk);
        reset = 1'b1;
        launch("u24_91x10", 0, 1'b0, 64'd91, 64'd10, 128'd910);

        run_op("s24_m3x7",  0, 1'b1, 64'hFFFFFD, 64'd7,      128'h0000_FFFF_FFFF_FFEB);
        run_op("s24_m3xm7", 0, 1'b1, 64'hFFFFFD, 64'hFFFFF9, 128'd21);
        run_op("u24_fd_x7", 0, 1'b0, 64'hFFFFFD, 64'd7,      128'h6FF_FFEB);
        run_op("s24_zero",  0, 1'b1, 64'd0,      64'hFFFFFB, 128'd0);
        run_op("u24_max",   0, 1'b0, 64'hFFFFFF, 64'hFFFFFF, 128'hFFFF_FE00_0001);
        run_op("s24_minsq", 0, 1'b1, 64'h800000, 64'h800000, 128'h4000_0000_0000);

        run_op("s8_minsq",   1, 1'b1, 64'h80, 64'h80, 128'd16384);
        run_op("u8_max",     1, 1'b0, 64'hFF, 64'hFF, 128'd65025);
        run_op("s8_7f_x_80", 1, 1'b1, 64'h7F, 64'h80, 128'hC080);
        run_op("s8_m1xm1",   1, 1'b1, 64'hFF, 64'hFF, 128'd1);
        run_op("nosign_ffx2", 2, 1'b1, 64'hFF, 64'h02, 128'd510);

        // Reset ten cycles into RUN aborts the operation.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 64'd91, 64'd10);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 64'd91, 64'd10);
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        reset   = 1'b0;
        start_v = 3'b111;
        @(posedge clk); #1;
        check("abort_p", get_p(0), 128'(0));
        check("abort_out_en", 128'(oe_v[0]), 128'(0));
        check("abort_busy", 128'(bz_v[0]), 128'(0));
        @(negedge clk);
        reset   = 1'b1;
        start_v = 3'b000;
        seen    = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            seen = seen | oe_v[0] | bz_v[1];
        end
        check("abort_no_out_en", 128'(seen), 128'(0));
        run_op("after_abort", 0, 1'b0, 64'd91, 64'd10, 128'd910);

        // start held high; operands change mid-RUN.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 64'd5, 64'd6);
        @(posedge clk); #1;
        k = 0;
        while (oe_v[0] !== 1'b1 && k < 100) begin
            @(posedge clk); #1;
            k++;
            if (k == 5) drive(0, 1'b1, 1'b0, 64'd7, 64'd8);
        end
        check("held_first_latency", 128'(k), 128'(25));
        check("held_first_p", get_p(0), 128'd30);
        m = 0;
        do begin
            @(posedge clk); #1;
            m++;
        end while (oe_v[0] !== 1'b1 && m < 100);
        check("held_spacing", 128'(m), 128'(27));
        check("held_second_p", get_p(0), 128'd56);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("held_idle_busy", 128'(bz_v[0]), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
